// File: rtl/tetris_board_engine.sv
// tetris_board_engine: playfield engine holding the settled board and the active
// four-cell piece, executing one piece command at a time over a valid/ready handshake.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (ready only while idle)
//   cmd_op               0 SPAWN, 1 LEFT, 2 RIGHT, 3 DOWN, 4 DROP, 5-7 illegal
//   fig_x, fig_y         spawn cell coordinates, cell i at [i*WIDTH +: WIDTH]
//   done, blocked, err   one-cycle completion pulse with status
//   piece_valid, piece_x, piece_y  active piece
//   board                settled cells, bit y*MEM_WIDTH+x, row 0 at the top
//   lines                saturating cleared-line counter
//   lose                 sticky game-over
//
// Build option: define TETRIS_HARD_DROP_EN to build the DROP op and DROP state;
// otherwise op 4 completes as an illegal op.
module tetris_board_engine #(
    parameter int unsigned MEM_WIDTH  = 10,
    parameter int unsigned MEM_HEIGHT = 20,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LINES_W    = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [2:0]                      cmd_op,
    input  logic [4*WIDTH-1:0]              fig_x,
    input  logic [4*WIDTH-1:0]              fig_y,
    output logic                            done,
    output logic                            blocked,
    output logic                            err,
    output logic                            piece_valid,
    output logic [4*WIDTH-1:0]              piece_x,
    output logic [4*WIDTH-1:0]              piece_y,
    output logic [MEM_WIDTH*MEM_HEIGHT-1:0] board,
    output logic [LINES_W-1:0]              lines,
    output logic                            lose
);

    localparam int unsigned CELLS = MEM_WIDTH * MEM_HEIGHT;
    localparam int unsigned IDX_W = $clog2(CELLS);
    localparam int unsigned ROW_W = $clog2(MEM_HEIGHT);
    localparam int unsigned PW    = 4 * WIDTH;

    localparam logic [2:0] OP_SPAWN = 3'd0;
    localparam logic [2:0] OP_LEFT  = 3'd1;
    localparam logic [2:0] OP_RIGHT = 3'd2;
    localparam logic [2:0] OP_DOWN  = 3'd3;
    localparam logic [2:0] OP_DROP  = 3'd4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MOVE = 3'd1,
        LOCK = 3'd2,
        SCAN = 3'd3,
        DROP = 3'd4,
        LOSE = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [PW-1:0]      fx_q, fx_d, fy_q, fy_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               cmd_ready_d, done_d, blocked_d, err_d, pv_d, lose_d;
    logic [PW-1:0]      px_d, py_d, cand_x, cand_y;
    logic [CELLS-1:0]   board_d;
    logic [LINES_W-1:0] lines_d;
    logic               row_full;

    // Any candidate cell outside the field or on a settled cell.
    function automatic logic hits(input logic [PW-1:0] cx, input logic [PW-1:0] cy,
                                  input logic [CELLS-1:0] brd);
        logic        hit;
        int unsigned xi;
        int unsigned yi;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            xi = 32'(cx[i*WIDTH +: WIDTH]);
            yi = 32'(cy[i*WIDTH +: WIDTH]);
            if (xi >= MEM_WIDTH || yi >= MEM_HEIGHT) begin
                hit = 1'b1;
            end else if (brd[IDX_W'(yi * MEM_WIDTH + xi)]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Step every cell coordinate by +1 or -1.
    function automatic logic [PW-1:0] step(input logic [PW-1:0] c, input logic up);
        logic [PW-1:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*WIDTH +: WIDTH] = up ? c[i*WIDTH +: WIDTH] + WIDTH'(1)
                                     : c[i*WIDTH +: WIDTH] - WIDTH'(1);
        end
        return r;
    endfunction

    // LEFT at column 0 must be refused rather than wrapping.
    function automatic logic any_zero(input logic [PW-1:0] c);
        logic z;
        z = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (c[i*WIDTH +: WIDTH] == '0) z = 1'b1;
        end
        return z;
    endfunction

    // Bit mask of the four piece cells.
    function automatic logic [CELLS-1:0] stamp(input logic [PW-1:0] cx, input logic [PW-1:0] cy);
        logic [CELLS-1:0] m;
        int unsigned      xi;
        int unsigned      yi;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            xi = 32'(cx[i*WIDTH +: WIDTH]);
            yi = 32'(cy[i*WIDTH +: WIDTH]);
            if (xi < MEM_WIDTH && yi < MEM_HEIGHT) m[IDX_W'(yi * MEM_WIDTH + xi)] = 1'b1;
        end
        return m;
    endfunction

    // Next-state and datapath.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        fx_d      = fx_q;
        fy_d      = fy_q;
        row_d     = row_q;
        done_d    = 1'b0;
        blocked_d = 1'b0;
        err_d     = 1'b0;
        pv_d      = piece_valid;
        px_d      = piece_x;
        py_d      = piece_y;
        board_d   = board;
        lines_d   = lines;
        lose_d    = lose;
        cand_x    = piece_x;
        cand_y    = piece_y;
        row_full  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d    = cmd_op;
                    fx_d    = fig_x;
                    fy_d    = fig_y;
                    state_d = MOVE;
                end
            end
            MOVE: begin
                state_d = IDLE;
                case (op_q)
                    OP_SPAWN: begin
                        done_d = 1'b1;
                        if (hits(fx_q, fy_q, board)) begin
                            blocked_d = 1'b1;
                            lose_d    = 1'b1;
                            state_d   = LOSE;
                        end else begin
                            px_d = fx_q;
                            py_d = fy_q;
                            pv_d = 1'b1;
                        end
                    end
                    OP_LEFT, OP_RIGHT: begin
                        done_d = 1'b1;
                        if (!piece_valid) begin
                            err_d = 1'b1;
                        end else begin
                            cand_x = step(piece_x, op_q == OP_RIGHT);
                            if ((op_q == OP_LEFT && any_zero(piece_x)) ||
                                hits(cand_x, piece_y, board)) begin
                                blocked_d = 1'b1;
                            end else begin
                                px_d = cand_x;
                            end
                        end
                    end
                    OP_DOWN: begin
                        if (!piece_valid) begin
                            done_d = 1'b1;
                            err_d  = 1'b1;
                        end else begin
                            cand_y = step(piece_y, 1'b1);
                            if (hits(piece_x, cand_y, board)) begin
                                state_d = LOCK;
                            end else begin
                                py_d   = cand_y;
                                done_d = 1'b1;
                            end
                        end
                    end
`ifdef TETRIS_HARD_DROP_EN
                    OP_DROP: begin
                        if (!piece_valid) begin
                            done_d = 1'b1;
                            err_d  = 1'b1;
                        end else begin
                            cand_y = step(piece_y, 1'b1);
                            if (hits(piece_x, cand_y, board)) begin
                                state_d = LOCK;
                            end else begin
                                py_d    = cand_y;
                                state_d = DROP;
                            end
                        end
                    end
`endif
                    default: begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                endcase
            end
`ifdef TETRIS_HARD_DROP_EN
            DROP: begin
                cand_y = step(piece_y, 1'b1);
                if (hits(piece_x, cand_y, board)) begin
                    state_d = LOCK;
                end else begin
                    py_d = cand_y;
                end
            end
`endif
            LOCK: begin
                board_d = board | stamp(piece_x, piece_y);
                pv_d    = 1'b0;
                row_d   = ROW_W'(MEM_HEIGHT - 1);
                state_d = SCAN;
            end
            SCAN: begin
                for (int r = 0; r < MEM_HEIGHT; r++) begin
                    if (row_q == ROW_W'(r)) row_full = &board[r*MEM_WIDTH +: MEM_WIDTH];
                end
                if (row_full) begin
                    // Collapse everything above the full row; the pointer stays
                    // so the row that slid down is checked next.
                    board_d[MEM_WIDTH-1:0] = '0;
                    for (int y = 1; y < MEM_HEIGHT; y++) begin
                        if (ROW_W'(y) <= row_q) begin
                            board_d[y*MEM_WIDTH +: MEM_WIDTH] = board[(y-1)*MEM_WIDTH +: MEM_WIDTH];
                        end
                    end
                    if (lines != {LINES_W{1'b1}}) lines_d = lines + LINES_W'(1);
                end else if (row_q == '0) begin
                    done_d    = 1'b1;
                    blocked_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    row_d = row_q - ROW_W'(1);
                end
            end
            LOSE: begin
                state_d = LOSE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Ready only after a full idle cycle, so it drops the edge a command is taken.
        cmd_ready_d = (state_q == IDLE) && (state_d == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            fx_q        <= '0;
            fy_q        <= '0;
            row_q       <= '0;
            cmd_ready   <= 1'b0;
            done        <= 1'b0;
            blocked     <= 1'b0;
            err         <= 1'b0;
            piece_valid <= 1'b0;
            piece_x     <= '0;
            piece_y     <= '0;
            board       <= '0;
            lines       <= '0;
            lose        <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            fx_q        <= fx_d;
            fy_q        <= fy_d;
            row_q       <= row_d;
            cmd_ready   <= cmd_ready_d;
            done        <= done_d;
            blocked     <= blocked_d;
            err         <= err_d;
            piece_valid <= pv_d;
            piece_x     <= px_d;
            piece_y     <= py_d;
            board       <= board_d;
            lines       <= lines_d;
            lose        <= lose_d;
        end
    end

endmodule

// File: tb/tb_tetris_board_engine.sv
// Testbench for tetris_board_engine: a reference board model predicts each
// command's outcome and completion latency; predictions go into a scoreboard
// queue and are compared when the engine pulses done.
module tb_tetris_board_engine;

    localparam int MW = 10;
    localparam int MH = 20;
    localparam int WD = 8;
    localparam int LW = 16;
    localparam int N  = MW * MH;

    logic            clk;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_op;
    logic [4*WD-1:0] fig_x;
    logic [4*WD-1:0] fig_y;
    logic            done;
    logic            blocked;
    logic            err;
    logic            piece_valid;
    logic [4*WD-1:0] piece_x;
    logic [4*WD-1:0] piece_y;
    logic [N-1:0]    board;
    logic [LW-1:0]   lines;
    logic            lose;

    tetris_board_engine #(
        .MEM_WIDTH (MW),
        .MEM_HEIGHT(MH),
        .WIDTH     (WD),
        .LINES_W   (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .fig_x      (fig_x),
        .fig_y      (fig_y),
        .done       (done),
        .blocked    (blocked),
        .err        (err),
        .piece_valid(piece_valid),
        .piece_x    (piece_x),
        .piece_y    (piece_y),
        .board      (board),
        .lines      (lines),
        .lose       (lose)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit              blocked;
        bit              err;
        bit              pv;
        logic [4*WD-1:0] px;
        logic [4*WD-1:0] py;
        logic [LW-1:0]   lines;
        logic [N-1:0]    brd;
        int              lat;
        bit              lose;
    } exp_t;

    exp_t sb[$];
    bit   mb[MH][MW];
    int   mpx[4];
    int   mpy[4];
    bit   mpv;
    int   mlines;
    bit   mlose;

    function automatic void m_reset();
        for (int y = 0; y < MH; y++)
            for (int x = 0; x < MW; x++) mb[y][x] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mpx[i] = 0;
            mpy[i] = 0;
        end
        mpv    = 1'b0;
        mlines = 0;
        mlose  = 1'b0;
    endfunction

    function automatic bit m_hit(input int x[4], input int y[4]);
        bit h = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (x[i] < 0 || x[i] >= MW || y[i] < 0 || y[i] >= MH) h = 1'b1;
            else if (mb[y[i]][x[i]]) h = 1'b1;
        end
        return h;
    endfunction

    function automatic logic [N-1:0] m_vec();
        logic [N-1:0] v = '0;
        for (int y = 0; y < MH; y++)
            for (int x = 0; x < MW; x++) v[y*MW + x] = mb[y][x];
        return v;
    endfunction

    function automatic logic [4*WD-1:0] m_pack(input int a[4]);
        logic [4*WD-1:0] v = '0;
        for (int i = 0; i < 4; i++) v[i*WD +: WD] = WD'(a[i]);
        return v;
    endfunction

    // Settle the piece and compact away full rows; returns rows cleared.
    function automatic int m_lock();
        bit nb[MH][MW];
        int k   = 0;
        int dst = MH - 1;
        bit full;
        for (int i = 0; i < 4; i++) mb[mpy[i]][mpx[i]] = 1'b1;
        mpv = 1'b0;
        for (int y = 0; y < MH; y++)
            for (int x = 0; x < MW; x++) nb[y][x] = 1'b0;
        for (int y = MH - 1; y >= 0; y--) begin
            full = 1'b1;
            for (int x = 0; x < MW; x++) if (!mb[y][x]) full = 1'b0;
            if (full) k++;
            else begin
                for (int x = 0; x < MW; x++) nb[dst][x] = mb[y][x];
                dst--;
            end
        end
        mb     = nb;
        mlines = (mlines + k > 65535) ? 65535 : mlines + k;
        return k;
    endfunction

    function automatic exp_t model_cmd(input logic [2:0] op, input int fx[4], input int fy[4]);
        exp_t e;
        int   nx[4];
        int   ny[4];
        int   k;
        int   d;
        bit   z;
        e.blocked = 1'b0;
        e.err     = 1'b0;
        e.lat     = 1;
        case (op)
            3'd0: begin
                if (m_hit(fx, fy)) begin
                    mlose     = 1'b1;
                    e.blocked = 1'b1;
                end else begin
                    mpx = fx;
                    mpy = fy;
                    mpv = 1'b1;
                end
            end
            3'd1, 3'd2: begin
                if (!mpv) e.err = 1'b1;
                else begin
                    z = 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        nx[i] = (op == 3'd2) ? mpx[i] + 1 : mpx[i] - 1;
                        if (mpx[i] == 0) z = 1'b1;
                    end
                    if ((op == 3'd1 && z) || m_hit(nx, mpy)) e.blocked = 1'b1;
                    else mpx = nx;
                end
            end
            3'd3: begin
                if (!mpv) e.err = 1'b1;
                else begin
                    for (int i = 0; i < 4; i++) ny[i] = mpy[i] + 1;
                    if (m_hit(mpx, ny)) begin
                        k         = m_lock();
                        e.blocked = 1'b1;
                        e.lat     = 2 + MH + k;
                    end else mpy = ny;
                end
            end
`ifdef TETRIS_HARD_DROP_EN
            3'd4: begin
                if (!mpv) e.err = 1'b1;
                else begin
                    d = 0;
                    for (int i = 0; i < 4; i++) ny[i] = mpy[i] + 1;
                    while (!m_hit(mpx, ny)) begin
                        mpy = ny;
                        d++;
                        for (int i = 0; i < 4; i++) ny[i] = mpy[i] + 1;
                    end
                    k         = m_lock();
                    e.blocked = 1'b1;
                    e.lat     = 2 + d + MH + k;
                end
            end
`endif
            default: e.err = 1'b1;
        endcase
        e.pv    = mpv;
        e.px    = m_pack(mpx);
        e.py    = m_pack(mpy);
        e.lines = LW'(mlines);
        e.brd   = m_vec();
        e.lose  = mlose;
        return e;
    endfunction

    // ---------------- stimulus ----------------
    int zf[4] = '{0, 0, 0, 0};
    int sx[4];
    int sy[4];

    task automatic wait_ready();
        int w = 0;
        while (cmd_ready !== 1'b1 && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
    endtask

    task automatic issue(input logic [2:0] op, input int fx[4], input int fy[4]);
        exp_t e;
        exp_t g;
        int   cyc;
        wait_ready();
        if (cmd_ready !== 1'b1) begin
            check("ready_timeout", {255'd0, cmd_ready}, 256'd1);
            return;
        end
        e = model_cmd(op, fx, fy);
        sb.push_back(e);
        cmd_op    = op;
        fig_x     = m_pack(fx);
        fig_y     = m_pack(fy);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (done !== 1'b1 && cyc < 1000);
        g = sb.pop_front();
        check("done_seen", {255'd0, done}, 256'd1);
        check("latency", 256'(cyc), 256'(g.lat));
        check("blocked", {255'd0, blocked}, {255'd0, g.blocked});
        check("err", {255'd0, err}, {255'd0, g.err});
        check("piece_valid", {255'd0, piece_valid}, {255'd0, g.pv});
        if (g.pv) begin
            check("piece_x", 256'(piece_x), 256'(g.px));
            check("piece_y", 256'(piece_y), 256'(g.py));
        end
        check("lines", 256'(lines), 256'(g.lines));
        check("board", 256'(board), 256'(g.brd));
        check("lose", {255'd0, lose}, {255'd0, g.lose});
        @(posedge clk);
        #1;
        check("done_pulse", {255'd0, done}, 256'd0);
        check("ready_after", {255'd0, cmd_ready}, {255'd0, !g.lose});
    endtask

    task automatic down_until_lock();
        int n = 0;
        while (mpv && n < 64) begin
            issue(3'd3, zf, zf);
            n++;
        end
    endtask

    task automatic spawn_and_lock(input int fx[4], input int fy[4]);
        issue(3'd0, fx, fy);
        down_until_lock();
    endtask

    bit saw_done;

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        fig_x     = '0;
        fig_y     = '0;
        m_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {255'd0, cmd_ready}, 256'd0);
        check("rst_done", {255'd0, done}, 256'd0);
        check("rst_pv", {255'd0, piece_valid}, 256'd0);
        check("rst_board", 256'(board), 256'd0);
        check("rst_lines", 256'(lines), 256'd0);
        check("rst_lose", {255'd0, lose}, 256'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", {255'd0, cmd_ready}, 256'd1);

        // Illegal op and moves without a piece
        issue(3'd6, zf, zf);
        issue(3'd3, zf, zf);
        issue(3'd1, zf, zf);

        // Spawn, then op 4 (hard drop when built, illegal otherwise)
        sx = '{4, 5, 4, 5};
        sy = '{0, 0, 1, 1};
        issue(3'd0, sx, sy);
        check("spawn_px", 256'(piece_x), 256'h05040504);
        issue(3'd4, zf, zf);
`ifdef TETRIS_HARD_DROP_EN
        check("drop_cells", {252'd0, board[19*MW+5], board[19*MW+4], board[18*MW+5], board[18*MW+4]}, 256'hf);
`endif

        // Reset three cycles into SCAN
        sx = '{0, 1, 0, 1};
        sy = '{18, 18, 19, 19};
        issue(3'd0, sx, sy);
        wait_ready();
        cmd_op    = 3'd3;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        void'(m_lock());
        repeat (5) @(posedge clk);
        #1;
        check("scan_board", 256'(board), 256'(m_vec()));
        rst = 1'b0;
        #1;
        check("midscan_board", 256'(board), 256'd0);
        check("midscan_lines", 256'(lines), 256'd0);
        check("midscan_pv", {255'd0, piece_valid}, 256'd0);
        check("midscan_done", {255'd0, done}, 256'd0);
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        saw_done = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("no_done_after_rst", {255'd0, saw_done}, 256'd0);
        check("midscan_ready", {255'd0, cmd_ready}, 256'd1);

        // Shifts against both walls
        sx = '{4, 5, 4, 5};
        sy = '{0, 0, 1, 1};
        issue(3'd0, sx, sy);
        repeat (5) issue(3'd1, zf, zf);
        check("left_wall_px", 256'(piece_x), 256'h01000100);
        repeat (9) issue(3'd2, zf, zf);
        check("right_wall_px", 256'(piece_x), 256'h09080908);

        // Preload rows 18/19 except columns 4/5, then clear both rows
        down_until_lock();
        for (int c = 0; c < 8; c += 2) begin
            if (c != 4) begin
                sx = '{c, c + 1, c, c + 1};
                spawn_and_lock(sx, sy);
            end
        end
        sx = '{4, 5, 4, 5};
        spawn_and_lock(sx, sy);
        check("two_lines", 256'(lines), 256'd2);
        check("cleared_board", 256'(board), 256'd0);

        // Fill column 4, then spawn on it
        sx = '{4, 4, 4, 4};
        sy = '{0, 1, 2, 3};
        repeat (5) spawn_and_lock(sx, sy);
        issue(3'd0, sx, sy);
        check("lose_flag", {255'd0, lose}, 256'd1);
        repeat (5) @(posedge clk);
        #1;
        check("lose_ready", {255'd0, cmd_ready}, 256'd0);
        check("lose_sticky", {255'd0, lose}, 256'd1);
        check("lose_board", 256'(board), 256'(m_vec()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
